// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage with an in-order prefetch queue between imem and decode.
// Redirects flush the queue and count in-flight responses that must be dropped.
module fetch_prefetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP_INSN = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            valid_d,
   input  logic            ready_d,
   output logic [31:0]     instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   logic [XLEN-1:0] fetchPc;
   logic [XLEN-1:0] pcQ [DEPTH];
   logic [31:0]     insnQ [DEPTH];
   logic [DEPTH-1:0] filledQ;

   ptr_t headPtr;
   ptr_t tailPtr;
   ptr_t fillIdx;
   cnt_t occ;
   cnt_t unfilled;
   cnt_t dropCnt;
   cnt_t redirDrop;

   logic [CW:0] inUse;
   logic [CW:0] dropSum;
   logic        reqFire;
   logic        fill;
   logic        drop;
   logic        pop;
   logic        headValid;
   logic [1:0]  unusedRedirLo;

   assign unusedRedirLo = redirect_pc[1:0];

   // Slots held by the queue plus responses still owed to a flushed stream.
   assign inUse = {1'b0, occ} + {1'b0, dropCnt};

   assign imem_req_valid = !rst && !redirect_valid
                           && (inUse < DEPTH_W);
   assign imem_req_addr  = fetchPc;
   assign reqFire        = imem_req_valid && imem_req_ready;

   // Unfilled entries are always the youngest ones, ending at the tail.
   assign fillIdx = tailPtr - ptr_t'(unfilled);
   assign drop    = imem_rsp_valid && (dropCnt != '0);
   assign fill    = imem_rsp_valid && (dropCnt == '0)
                    && (unfilled != '0);

   assign headValid = (occ != '0) && filledQ[headPtr];
   assign pop       = headValid && ready_d;

   assign dropSum   = {1'b0, dropCnt} + {1'b0, unfilled};
   assign redirDrop = (imem_rsp_valid && dropSum != '0)
                      ? cnt_t'(dropSum - 1'b1)
                      : cnt_t'(dropSum);

   always_comb begin
      valid_d    = headValid;
      instr_d    = NOP_INSN;
      pc_d       = '0;
      pc_plus4_d = '0;
      if (headValid) begin
         instr_d    = insnQ[headPtr];
         pc_d       = pcQ[headPtr];
         pc_plus4_d = pcQ[headPtr] + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc  <= RESET_PC;
         headPtr  <= '0;
         tailPtr  <= '0;
         occ      <= '0;
         unfilled <= '0;
         dropCnt  <= '0;
         filledQ  <= '0;
      end else if (redirect_valid) begin
         fetchPc  <= {redirect_pc[XLEN-1:2], 2'b00};
         headPtr  <= tailPtr;
         occ      <= '0;
         unfilled <= '0;
         dropCnt  <= redirDrop;
      end else begin
         if (reqFire) begin
            pcQ[tailPtr]     <= fetchPc;
            filledQ[tailPtr] <= 1'b0;
            tailPtr          <= tailPtr + ptr_t'(1);
            fetchPc          <= fetchPc + XLEN'(4);
         end
         if (fill) begin
            insnQ[fillIdx]   <= imem_rsp_data;
            filledQ[fillIdx] <= 1'b1;
         end
         if (drop) begin
            dropCnt <= dropCnt - cnt_t'(1);
         end
         if (pop) begin
            headPtr <= headPtr + ptr_t'(1);
         end
         occ      <= occ + cnt_t'(reqFire) - cnt_t'(pop);
         unfilled <= unfilled + cnt_t'(reqFire) - cnt_t'(fill);
      end
   end

endmodule
